// File: rtl/spi_master.sv
// SPI mode-0 master: 8-bit frames, MSB first, sck half-period of CLK_DIV clk cycles.
// Three-state control (IDLE/TRANSFER/DONE) with a registered serial interface.
module spi_master #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic       miso,
    output logic       mosi,
    output logic       sck,
    output logic       cs,
    output logic       done,
    output logic [7:0] data_out,
    output logic       busy
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        TRANSFER,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       tx_q, tx_d;
    logic [7:0]       rx_q, rx_d;
    logic [7:0]       dout_q, dout_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             sck_q, sck_d;
    logic             cs_q, cs_d;
    logic             tick;

    assign tick = (div_q == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tx_q    <= 8'h00;
            rx_q    <= 8'h00;
            dout_q  <= 8'h00;
            cnt_q   <= 4'd0;
            div_q   <= '0;
            sck_q   <= 1'b0;
            cs_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            sck_q   <= sck_d;
            cs_q    <= cs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        sck_d   = sck_q;
        cs_d    = cs_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    tx_d    = data_in;
                    rx_d    = 8'h00;
                    cs_d    = 1'b0;
                    sck_d   = 1'b0;
                    cnt_d   = 4'd0;
                    div_d   = '0;
                    state_d = TRANSFER;
                end
            end
            TRANSFER: begin
                if (tick) begin
                    div_d = '0;
                    sck_d = ~sck_q;
                    cnt_d = cnt_q + 4'd1;
                    if (!sck_q) begin
                        rx_d = {rx_q[6:0], miso};
                    end else if (cnt_q == 4'd15) begin
                        // Final falling toggle: close the frame; clearing tx drops mosi to 0.
                        tx_d    = 8'h00;
                        cs_d    = 1'b1;
                        dout_d  = rx_q;
                        state_d = DONE;
                    end else begin
                        tx_d = {tx_q[6:0], 1'b0};
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // mosi is the tx MSB directly, so it only moves on falling toggles.
    assign mosi     = tx_q[7];
    assign sck      = sck_q;
    assign cs       = cs_q;
    assign data_out = dout_q;
    assign done     = (state_q == DONE);
    assign busy     = (state_q == TRANSFER);

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (CLK_DIV=2 and CLK_DIV=1) behind an output mux,
// with a slave model and a frame-level reference derived from the protocol rules.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       miso;
    logic [7:0] data_in;
    logic       sel;

    logic       start2, start1;
    logic       mosi2, sck2, cs2, done2, busy2;
    logic       mosi1, sck1, cs1, done1, busy1;
    logic [7:0] dout2, dout1;
    logic       mosi_m, sck_m, cs_m, done_m, busy_m;
    logic [7:0] dout_m;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign start2 = start & ~sel;
    assign start1 = start & sel;

    spi_master #(.CLK_DIV(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .data_in(data_in), .miso(miso),
        .mosi(mosi2), .sck(sck2), .cs(cs2), .done(done2), .data_out(dout2), .busy(busy2)
    );

    spi_master #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .data_in(data_in), .miso(miso),
        .mosi(mosi1), .sck(sck1), .cs(cs1), .done(done1), .data_out(dout1), .busy(busy1)
    );

    assign mosi_m = sel ? mosi1 : mosi2;
    assign sck_m  = sel ? sck1  : sck2;
    assign cs_m   = sel ? cs1   : cs2;
    assign done_m = sel ? done1 : done2;
    assign busy_m = sel ? busy1 : busy2;
    assign dout_m = sel ? dout1 : dout2;

    // Frame observations, edge indices counted from the acceptance edge (edge 0).
    int         ob_done_cnt, ob_done_e, ob_rise_cnt, ob_first_rise_e, ob_last_fall_e;
    int         ob_cs_viol, ob_mosi_viol, ob_busy_early, ob_busy_after, ob_restart;
    logic [7:0] ob_mosi_bits, ob_dout;

    // Runs one frame: slave shifts rxb out MSB first, changing miso after each sck fall.
    task automatic run_frame(input int div, input logic [7:0] tx, input logic [7:0] rxb,
                             input bit poke);
        int   idx;
        logic prev_sck;
        logic held_mosi;
        ob_done_cnt = 0; ob_done_e = -1; ob_rise_cnt = 0; ob_first_rise_e = -1;
        ob_last_fall_e = -1; ob_cs_viol = 0; ob_mosi_viol = 0; ob_busy_early = 0;
        ob_busy_after = 0; ob_restart = 0; ob_mosi_bits = 8'h00; ob_dout = 8'h00;
        idx = 0; prev_sck = 1'b0; held_mosi = 1'b0;
        @(negedge clk);
        data_in = tx;
        miso    = rxb[7];
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        data_in = ~tx;
        for (int e = 0; e < 16 * div + 6; e++) begin
            @(negedge clk);
            if (poke && (e == 5 || e == 16 * div)) begin
                start   = 1'b1;
                data_in = 8'h3C;
            end else if (poke && (e == 6 || e == 16 * div + 1)) begin
                start = 1'b0;
            end
            if (done_m) begin
                ob_done_cnt++;
                if (ob_done_e < 0) ob_done_e = e;
                ob_dout = dout_m;
                if (!cs_m) ob_cs_viol++;
            end else if (ob_done_e < 0) begin
                if (cs_m) ob_cs_viol++;
                if (!busy_m) ob_busy_early++;
            end else if (!cs_m) begin
                ob_restart++;
            end
            if (ob_done_e >= 0 && busy_m) ob_busy_after++;
            if (cs_m && sck_m) ob_cs_viol++;
            if (!prev_sck && sck_m) begin
                if (ob_rise_cnt < 8) ob_mosi_bits[7 - ob_rise_cnt] = mosi_m;
                if (ob_first_rise_e < 0) ob_first_rise_e = e;
                ob_rise_cnt++;
                held_mosi = mosi_m;
            end else if (sck_m && (mosi_m !== held_mosi)) begin
                ob_mosi_viol++;
            end
            if (prev_sck && !sck_m) begin
                ob_last_fall_e = e;
                idx++;
                if (idx < 8) miso = rxb[7 - idx];
            end
            prev_sck = sck_m;
        end
    endtask

    task automatic test_reset();
        total++; if (cs2 !== 1'b1 || cs1 !== 1'b1) begin bad++; $display("FAIL reset_cs: got %b/%b want 1/1", cs2, cs1); end
        total++; if (sck2 !== 1'b0 || sck1 !== 1'b0) begin bad++; $display("FAIL reset_sck: got %b/%b want 0/0", sck2, sck1); end
        total++; if (mosi2 !== 1'b0 || mosi1 !== 1'b0) begin bad++; $display("FAIL reset_mosi: got %b/%b want 0/0", mosi2, mosi1); end
        total++; if (done2 !== 1'b0 || busy2 !== 1'b0 || done1 !== 1'b0 || busy1 !== 1'b0) begin bad++; $display("FAIL reset_done_busy: got %b%b/%b%b want 00/00", done2, busy2, done1, busy1); end
        total++; if (dout2 !== 8'h00 || dout1 !== 8'h00) begin bad++; $display("FAIL reset_data_out: got %h/%h want 00/00", dout2, dout1); end
    endtask

    task automatic test_basic();
        sel = 1'b0;
        run_frame(2, 8'hA5, 8'hF2, 1'b0);
        total++; if (ob_mosi_bits !== 8'hA5) begin bad++; $display("FAIL basic_mosi: got %h want a5", ob_mosi_bits); end
        total++; if (ob_rise_cnt != 8) begin bad++; $display("FAIL basic_sck_pulses: got %0d want 8", ob_rise_cnt); end
        total++; if (ob_cs_viol != 0) begin bad++; $display("FAIL basic_cs: got %0d violations want 0", ob_cs_viol); end
        total++; if (ob_done_cnt != 1) begin bad++; $display("FAIL basic_done_count: got %0d want 1", ob_done_cnt); end
        total++; if (ob_dout !== 8'hF2) begin bad++; $display("FAIL basic_data_out: got %h want f2", ob_dout); end
        total++; if (ob_mosi_viol != 0) begin bad++; $display("FAIL basic_mosi_stable: got %0d violations want 0", ob_mosi_viol); end
    endtask

    task automatic test_timing();
        logic [7:0] t, r;
        sel = 1'b0;
        t = 8'($urandom); r = 8'($urandom);
        run_frame(2, t, r, 1'b0);
        total++; if (ob_first_rise_e != 2) begin bad++; $display("FAIL timing_first_rise: got %0d want 2", ob_first_rise_e); end
        total++; if (ob_last_fall_e != 32) begin bad++; $display("FAIL timing_last_fall: got %0d want 32", ob_last_fall_e); end
        total++; if (ob_done_e != 32 || ob_done_cnt != 1) begin bad++; $display("FAIL timing_done: got edge %0d count %0d want edge 32 count 1", ob_done_e, ob_done_cnt); end
        total++; if (ob_busy_early != 0 || ob_busy_after != 0) begin bad++; $display("FAIL timing_busy: got early %0d after %0d want 0 0", ob_busy_early, ob_busy_after); end
        total++; if (ob_mosi_bits !== t || ob_dout !== r) begin bad++; $display("FAIL timing_data: got %h/%h want %h/%h", ob_mosi_bits, ob_dout, t, r); end
    endtask

    task automatic test_ignored_start();
        logic [7:0] r;
        sel = 1'b0;
        r = 8'($urandom);
        run_frame(2, 8'h5A, r, 1'b1);
        total++; if (ob_mosi_bits !== 8'h5A) begin bad++; $display("FAIL ignored_mosi: got %h want 5a", ob_mosi_bits); end
        total++; if (ob_done_cnt != 1 || ob_done_e != 32) begin bad++; $display("FAIL ignored_done: got count %0d edge %0d want 1 32", ob_done_cnt, ob_done_e); end
        total++; if (ob_restart != 0) begin bad++; $display("FAIL ignored_no_second_frame: got %0d cs-low cycles want 0", ob_restart); end
        total++; if (ob_dout !== r) begin bad++; $display("FAIL ignored_data_out: got %h want %h", ob_dout, r); end
    endtask

    task automatic test_reset_mid();
        int rises, dones, cslow;
        logic prev_sck;
        logic [7:0] r;
        sel = 1'b0;
        rises = 0; dones = 0; cslow = 0; prev_sck = 1'b0;
        @(negedge clk);
        data_in = 8'($urandom); miso = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 40 && rises < 4; i++) begin
            @(negedge clk);
            if (!prev_sck && sck2) rises++;
            prev_sck = sck2;
        end
        total++; if (rises != 4) begin bad++; $display("FAIL rstmid_reach_rise4: got %0d rises want 4", rises); end
        reset = 1'b1;
        #1;
        total++; if (cs2 !== 1'b1 || sck2 !== 1'b0 || mosi2 !== 1'b0) begin bad++; $display("FAIL rstmid_pins: got cs %b sck %b mosi %b want 1 0 0", cs2, sck2, mosi2); end
        total++; if (done2 !== 1'b0 || busy2 !== 1'b0 || dout2 !== 8'h00) begin bad++; $display("FAIL rstmid_status: got done %b busy %b dout %h want 0 0 00", done2, busy2, dout2); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done2) dones++;
            if (!cs2) cslow++;
        end
        total++; if (dones != 0 || cslow != 0) begin bad++; $display("FAIL rstmid_aborted: got done %0d cs-low %0d want 0 0", dones, cslow); end
        r = 8'($urandom);
        run_frame(2, 8'hC3, r, 1'b0);
        total++; if (ob_mosi_bits !== 8'hC3 || ob_dout !== r || ob_done_e != 32) begin bad++; $display("FAIL rstmid_next_frame: got mosi %h dout %h done@%0d want c3 %h 32", ob_mosi_bits, ob_dout, ob_done_e, r); end
    endtask

    task automatic test_back_to_back();
        int         dcnt, rcnt, fall_e, extra;
        int         done_e[2];
        logic [7:0] dv[2];
        logic [15:0] bits;
        logic       prev_cs, prev_sck;
        sel = 1'b0;
        dcnt = 0; rcnt = 0; fall_e = -1; extra = 0; bits = 16'h0000;
        done_e[0] = -1; done_e[1] = -1; dv[0] = 8'h00; dv[1] = 8'h00;
        prev_cs = 1'b0; prev_sck = 1'b0;
        @(negedge clk);
        data_in = 8'hFF; miso = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 data_in = 8'h00;
        for (int e = 0; e < 80; e++) begin
            @(negedge clk);
            if (done2) begin
                if (dcnt < 2) begin done_e[dcnt] = e; dv[dcnt] = dout2; end
                dcnt++;
                if (dcnt == 2) start = 1'b0;
            end
            if (prev_cs && !cs2 && fall_e < 0) fall_e = e;
            if (dcnt >= 2 && !done2 && !cs2) extra++;
            if (!prev_sck && sck2) begin
                if (rcnt < 16) bits[15 - rcnt] = mosi2;
                rcnt++;
            end
            prev_cs = cs2; prev_sck = sck2;
        end
        start = 1'b0;
        total++; if (dcnt != 2) begin bad++; $display("FAIL b2b_done_count: got %0d want 2", dcnt); end
        total++; if (done_e[0] != 32 || fall_e != 34 || done_e[1] != 66) begin bad++; $display("FAIL b2b_timing: got done %0d cs-fall %0d done %0d want 32 34 66", done_e[0], fall_e, done_e[1]); end
        total++; if (dv[0] !== 8'hFF || dv[1] !== 8'hFF) begin bad++; $display("FAIL b2b_data_out: got %h/%h want ff/ff", dv[0], dv[1]); end
        total++; if (bits !== 16'hFF00 || rcnt != 16) begin bad++; $display("FAIL b2b_mosi: got %h (%0d rises) want ff00 (16)", bits, rcnt); end
        total++; if (extra != 0) begin bad++; $display("FAIL b2b_no_third_frame: got %0d want 0", extra); end
    endtask

    task automatic test_div1();
        sel = 1'b1;
        run_frame(1, 8'h81, 8'h00, 1'b0);
        total++; if (ob_first_rise_e != 1 || ob_last_fall_e != 16 || ob_rise_cnt != 8) begin bad++; $display("FAIL div1_sck: got rise@%0d fall@%0d pulses %0d want 1 16 8", ob_first_rise_e, ob_last_fall_e, ob_rise_cnt); end
        total++; if (ob_done_e != 16 || ob_done_cnt != 1) begin bad++; $display("FAIL div1_done: got edge %0d count %0d want 16 1", ob_done_e, ob_done_cnt); end
        total++; if (ob_mosi_bits !== 8'h81) begin bad++; $display("FAIL div1_mosi: got %h want 81", ob_mosi_bits); end
        total++; if (ob_dout !== 8'h00) begin bad++; $display("FAIL div1_data_out: got %h want 00", ob_dout); end
        sel = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] t, r;
        int         div;
        for (int n = 0; n < 8; n++) begin
            sel = 1'($urandom_range(0, 1));
            div = sel ? 1 : 2;
            t = 8'($urandom); r = 8'($urandom);
            run_frame(div, t, r, 1'b0);
            total++;
            if (ob_mosi_bits !== t || ob_dout !== r || ob_done_e != 16 * div || ob_done_cnt != 1
                || ob_cs_viol != 0 || ob_mosi_viol != 0) begin
                bad++;
                $display("FAIL random_%0d: got mosi %h dout %h done@%0d x%0d csv %0d mv %0d want %h %h %0d x1 0 0",
                         n, ob_mosi_bits, ob_dout, ob_done_e, ob_done_cnt, ob_cs_viol, ob_mosi_viol,
                         t, r, 16 * div);
            end
        end
        sel = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; miso = 1'b0; data_in = 8'h00; sel = 1'b0;
        #3;
        test_reset();
        #7 reset = 1'b0;
        test_basic();
        test_timing();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        test_div1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
